// File: rtl/fp_pkg.sv
// Shared single-precision float constants and FSM state type for the FP datapath.
package fp_pkg;

    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MANT_W   = 23;
    localparam int unsigned BIAS     = 127;

    localparam int unsigned WORD_W   = 1 + EXP_W + MANT_W;
    localparam int unsigned SIG_W    = MANT_W + 1;
    localparam int unsigned REM_W    = SIG_W + 1;
    localparam int unsigned Q_W      = SIG_W + 1;
    localparam int unsigned CNT_W    = 5;

    localparam int unsigned SIGN_BIT = WORD_W - 1;
    localparam int unsigned EXP_MSB  = WORD_W - 2;
    localparam int unsigned EXP_LSB  = MANT_W;
    localparam int unsigned FRAC_MSB = MANT_W - 1;
    localparam int unsigned FRAC_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/float_divider_if.sv
// Operand/result handshake bundle for the float divider.
interface float_divider_if;
    import fp_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] Dividend;
    logic [WORD_W-1:0] Divisor;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] Result;
    logic              div_by_zero;

    modport master (
        output in_valid, Dividend, Divisor, out_ready,
        input  in_ready, out_valid, Result, div_by_zero
    );

    modport slave (
        input  in_valid, Dividend, Divisor, out_ready,
        output in_ready, out_valid, Result, div_by_zero
    );

endinterface

// File: rtl/mant_div_step.sv
// One restoring radix-2 division step: compare, conditionally subtract, shift.
module mant_div_step
    import fp_pkg::*;
(
    input  logic [REM_W-1:0] r,
    input  logic [SIG_W-1:0] v,
    output logic [REM_W-1:0] r_next_c,
    output logic             q_bit_c
);

    logic [REM_W-1:0] v_ext;
    logic [REM_W-1:0] sel;

    // Subtract when the divisor fits, then shift the remainder up one place.
    always_comb begin
        v_ext    = {1'b0, v};
        q_bit_c  = (r >= v_ext);
        sel      = q_bit_c ? (r - v_ext) : r;
        r_next_c = sel << 1;
    end

endmodule

// File: rtl/float_divider.sv
// Sequential IEEE-754 single-precision divider, one quotient bit per clock.
module float_divider
    import fp_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    float_divider_if.slave bus
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [REM_W-1:0]   rem;
    logic [SIG_W-1:0]   vdiv;
    logic [Q_W-1:0]     quo;
    logic               sign;
    logic [EXP_W-1:0]   exp_a;
    logic [EXP_W-1:0]   exp_b;
    logic               dz;
    logic               zr;

    logic [REM_W-1:0]   rem_next;
    logic               q_bit;
    logic [MANT_W-1:0]  frac_n;
    logic [EXP_W-1:0]   exp_n;

    mant_div_step u_step (
        .r        (rem),
        .v        (vdiv),
        .r_next_c (rem_next),
        .q_bit_c  (q_bit)
    );

    // Normalize the raw quotient and jam discarded bits plus remainder into the LSB.
    always_comb begin
        frac_n = '0;
        exp_n  = '0;
        if (quo[Q_W-1]) begin
            frac_n = {quo[Q_W-2:2], quo[1] | quo[0] | (|rem)};
            exp_n  = exp_a - exp_b + EXP_W'(BIAS);
        end else begin
            frac_n = {quo[Q_W-3:1], quo[0] | (|rem)};
            exp_n  = exp_a - exp_b + EXP_W'(BIAS - 1);
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            rem             <= '0;
            vdiv            <= '0;
            quo             <= '0;
            sign            <= 1'b0;
            exp_a           <= '0;
            exp_b           <= '0;
            dz              <= 1'b0;
            zr              <= 1'b0;
            bus.in_ready    <= 1'b1;
            bus.out_valid   <= 1'b0;
            bus.Result      <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        sign         <= bus.Dividend[SIGN_BIT] ^ bus.Divisor[SIGN_BIT];
                        exp_a        <= bus.Dividend[EXP_MSB:EXP_LSB];
                        exp_b        <= bus.Divisor[EXP_MSB:EXP_LSB];
                        rem          <= {2'b01, bus.Dividend[FRAC_MSB:FRAC_LSB]};
                        vdiv         <= {1'b1, bus.Divisor[FRAC_MSB:FRAC_LSB]};
                        quo          <= '0;
                        dz           <= (bus.Divisor[EXP_MSB:0] == '0);
                        zr           <= (bus.Dividend[EXP_MSB:0] == '0);
                        cnt          <= CNT_W'(SIG_W);
                        bus.in_ready <= 1'b0;
                        state        <= DIV;
                    end
                end
                DIV: begin
                    rem <= rem_next;
                    quo <= {quo[Q_W-2:0], q_bit};
                    if (cnt == '0) begin
                        state <= NORM;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                NORM: begin
                    if (dz) begin
                        bus.Result <= {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
                    end else if (zr) begin
                        bus.Result <= {sign, {(WORD_W-1){1'b0}}};
                    end else begin
                        bus.Result <= {sign, exp_n, frac_n};
                    end
                    bus.div_by_zero <= dz;
                    state           <= HOLD;
                end
                HOLD: begin
                    // Result settles one cycle before being offered downstream.
                    if (!bus.out_valid) begin
                        bus.out_valid <= 1'b1;
                    end else if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_divider.sv
// Self-checking bench for float_divider: directed vectors, corner sequences, random vs model.
module tb_float_divider;
    import fp_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    float_divider_if bus();

    float_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        dz;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference: plain integer division of the significands, then the rounding rules.
    function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic              s;
        longint unsigned   d, v, q, r;
        logic [22:0]       f;
        logic [7:0]        e;
        int                ea, eb;
        s = a[31] ^ b[31];
        if (b[30:0] == 31'h0) return {1'b1, s, 8'hFF, 23'h0};
        if (a[30:0] == 31'h0) return {1'b0, s, 31'h0};
        d  = 64'h800000 + 64'(a[22:0]);
        v  = 64'h800000 + 64'(b[22:0]);
        q  = (d << 24) / v;
        r  = (d << 24) % v;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (q >= 64'h1000000) begin
            f = 23'((q >> 1) & 64'h7FFFFF);
            if ((q & 64'h1) != 0 || r != 0) f = f | 23'h1;
            e = 8'(ea - eb + 127);
        end else begin
            f = 23'(q & 64'h7FFFFF);
            if (r != 0) f = f | 23'h1;
            e = 8'(ea - eb + 126);
        end
        return {1'b0, s, e, f};
    endfunction

    task automatic accept(input logic [31:0] a, input logic [31:0] b);
        int g;
        g = 0;
        bus.Dividend = a;
        bus.Divisor  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && g < 200) begin
            @(posedge clk); #1; g++;
        end
        check("accept_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] a, b;
        logic [32:0] m;
        int          stall;

        vecs[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0};
        vecs[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0};
        vecs[2] = '{32'hC0F00000, 32'h40200000, 32'hC0400000, 1'b0};
        vecs[3] = '{32'h3F800000, 32'h80000000, 32'hFF800000, 1'b1};
        vecs[4] = '{32'h00000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[5] = '{32'h00000000, 32'h80000000, 32'hFF800000, 1'b1};
        vecs[6] = '{32'h80000000, 32'h40000000, 32'h80000000, 1'b0};

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.Dividend  = '0;
        bus.Divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_result", bus.Result, 32'h0);
        check("reset_dz", 32'(bus.div_by_zero), 32'd0);

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            accept(vecs[i].a, vecs[i].b);
            wait_valid(lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd27);
            check($sformatf("vec%0d_result", i), bus.Result, vecs[i].res);
            check($sformatf("vec%0d_dz", i), 32'(bus.div_by_zero), 32'(vecs[i].dz));
            handshake();
            check($sformatf("vec%0d_valid_drop", i), 32'(bus.out_valid), 32'd0);
        end

        // Backpressure with a second request held during HOLD.
        accept(32'h40C00000, 32'h40000000);
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'd27);
        bus.Dividend = 32'h3F800000;
        bus.Divisor  = 32'h40400000;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_result_held", bus.Result, 32'h40400000);
            check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
            check("bp_valid_held", 32'(bus.out_valid), 32'd1);
        end
        handshake();
        check("bp_after_hs_valid", 32'(bus.out_valid), 32'd0);
        check("bp_after_hs_ready", 32'(bus.in_ready), 32'd1);
        accept(32'h3F800000, 32'h40400000);
        wait_valid(lat);
        check("bp_second_latency", 32'(lat), 32'd27);
        check("bp_second_result", bus.Result, 32'h3EAAAAAB);
        handshake();

        // Reset in the middle of a division.
        accept(32'h40C00000, 32'h40000000);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_result", bus.Result, 32'h0);
        accept(32'h40C00000, 32'h40000000);
        wait_valid(lat);
        check("midrst_latency", 32'(lat), 32'd27);
        check("midrst_result_after", bus.Result, 32'h40400000);
        handshake();

        // Random operands against the reference model, random output stalls.
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 10 == 3) b[30:0] = 31'h0;
            if (i % 10 == 7) a[30:0] = 31'h0;
            m = ref_div(a, b);
            accept(a, b);
            wait_valid(lat);
            check($sformatf("rnd%0d_result(%h/%h)", i, a, b), bus.Result, m[31:0]);
            check($sformatf("rnd%0d_dz", i), 32'(bus.div_by_zero), 32'(m[32]));
            stall = int'($urandom_range(0, 3));
            for (int k = 0; k < stall; k++) begin
                @(posedge clk); #1;
                check($sformatf("rnd%0d_stall", i), bus.Result, m[31:0]);
            end
            handshake();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/float_divider.md
Name: float_divider

Overview:
- Sequential IEEE-754 single-precision divider; the inverse operation of the team's combinational float multiplier.
- Computes Dividend / Divisor with a restoring radix-2 mantissa divider, one quotient bit per clock.
- Numeric conventions match the multiplier: normalized operands only, exponent arithmetic modulo 256, truncation with a sticky-jammed LSB.
- Valid/ready handshake on both sides, so it drops into the FP datapath next to the multiplier.

Parameters:
- EXP_W, 8, exponent field width.
- MANT_W, 23, stored fraction width.
- BIAS, 127, exponent bias.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- Dividend  in  32  IEEE-754 single-precision.
- Divisor  in  32  IEEE-754 single-precision.
- out_valid  out  1  Result valid.
- out_ready  in  1  consumer accepts Result.
- Result  out  32  quotient.
- div_by_zero  out  1  qualifies Result; valid while out_valid=1.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, Result=0, div_by_zero=0; internal registers cleared.
  - Reset mid-operation abandons the division; the next cycle is IDLE.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch operands and go to DIV with counter=24.
  - DIV: 25 cycles, counter 24..0.
  - NORM: 1 cycle.
  - HOLD: out_valid=1 until out_ready, then IDLE.
- in_ready is 0 outside IDLE, so there is no overlap between operations.
- Latency: operands accepted on edge N; out_valid=1 from edge N+27.
- HOLD backpressure: Result and div_by_zero stay stable while out_ready=0.
- HOLD to IDLE: on out_ready=1 in HOLD, the next cycle is IDLE with out_valid=0. A new operation can be accepted one cycle after the handshake.
- Sign: Result[31] = Dividend[31] XOR Divisor[31], in all cases.
- Mantissa division:
  - D = {1,Dividend[22:0]}, V = {1,Divisor[22:0]}, 24 bits each.
  - Partial remainder R is 25 bits and is initialized to D.
  - Each DIV cycle: if R >= V then q_bit=1 and R=R-V, else q_bit=0. Shift q_bit into Q, then R = R<<1.
  - After 25 cycles, Q[24:0] = floor(D*2^24/V) and Q lies in [2^23, 2^25). rnz = (R != 0).
- NORM:
  - If Q[24]=1: fraction = {Q[23:2], Q[1]|Q[0]|rnz}; exponent = Ea - Eb + 127.
  - Else (Q[23]=1 is guaranteed): fraction = {Q[22:1], Q[0]|rnz}; exponent = Ea - Eb + 126.
  - Exponent is computed in EXP_W bits and wraps modulo 256. Overflow and underflow are not detected, matching the multiplier.
- Special cases, decided at acceptance and still observing full latency:
  - Divisor == 0 with sign ignored (Divisor[30:0]=0): Result={sign,8'hFF,23'h0}, div_by_zero=1.
  - Otherwise, Dividend[30:0]=0: Result={sign,31'h0}, div_by_zero=0.
  - Both zero: div_by_zero takes priority.
  - NaN, Inf and denormal inputs are treated as normal numbers (unsupported).
- Simultaneous events: rst wins over any handshake. in_valid while busy is ignored; the upstream must hold its operands.

Decomposition:
- Shared package fp_pkg:
  - EXP_W, MANT_W, BIAS.
  - State enum {IDLE, DIV, NORM, HOLD}.
  - Field-slice helper constants SIGN_BIT, EXP_MSB/LSB, FRAC_MSB/LSB, also used by the float multiplier.
- One natural sub-module: mant_div_step. It is the combinational restoring step: R and V in, next R and q_bit out. It is instantiated once and iterated by the FSM.

Test Plan:
- 0x40C00000 / 0x40000000 (6.0/2.0) -> Result 0x40400000, div_by_zero=0, out_valid exactly 27 cycles after accept.
- 0x3F800000 / 0x40400000 (1.0/3.0) -> Result 0x3EAAAAAB (remainder nonzero jams LSB).
- 0xC0F00000 / 0x40200000 (-7.5/2.5) -> Result 0xC0400000.
- 0x3F800000 / 0x80000000 -> Result 0xFF800000, div_by_zero=1; then 0x00000000 / 0x40000000 -> Result 0x00000000, div_by_zero=0.
- Backpressure: 6.0/2.0 with out_ready=0 for 5 cycles after out_valid -> Result held at 0x40400000, in_ready=0 throughout. A second in_valid is ignored until the handshake; the second op then completes correctly.
- rst asserted 10 cycles into DIV -> next cycle in_ready=1, out_valid=0, Result=0. A fresh 6.0/2.0 then yields 0x40400000.
